rst_sequencer: RTL and testbench
================================

# rst_sequencer

Power-up and lock-loss reset sequencer in the mem_clk domain. It consumes the raw PLL lock indication and the system reset, then releases per-subsystem resets in a fixed order: memory first, then video after the SDRAM controller reports init complete, then USB. Any later loss of lock re-asserts all downstream resets and restarts the sequence. It sits directly after the clock generator and feeds the SDRAM controller, the video pipeline and the USB host logic.

## Interface
- LOCK_STABLE_CYCLES, 1024: consecutive cycles lock must stay high before memory reset release (>=2).
- INIT_TIMEOUT, 65536: cycles allowed in WAIT_INIT before declaring a fault (>=2).
- mem_clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and all reset outputs high immediately.
- locked_in  in  1  raw PLL lock, asynchronous to mem_clk.
- mem_init_done  in  1  SDRAM controller init complete, synchronous to mem_clk; level.
- mem_rst  out  1  memory subsystem reset, active-high.
- video_rst  out  1  video pipeline reset, active-high.
- usb_rst  out  1  USB logic reset, active-high.
- seq_state  out  3  current state encoding.
- lock_loss_cnt  out  8  saturating count of lock-loss events.
- init_timeout  out  1  sticky fault flag.

## Operation
- locked_in passes through a 2-flop synchronizer; the result is lock_s. Sync flops reset to 0.
- States and seq_state codes: IDLE=0, WAIT_LOCK=1, STABLE=2, REL_MEM=3, WAIT_INIT=4, REL_VIDEO=5, RUN=6, FAULT=7.
- IDLE: always moves to WAIT_LOCK on the next edge.
- WAIT_LOCK: clear stable counter; on lock_s=1 go to STABLE.
- STABLE: increment counter while lock_s=1; on counter==LOCK_STABLE_CYCLES-1 go to REL_MEM.
- REL_MEM: mem_rst=0; go to WAIT_INIT next edge; clear timeout counter.
- WAIT_INIT: increment timeout counter. If mem_init_done=1, go to REL_VIDEO; this has priority over the timeout if both occur on the same cycle. On counter==INIT_TIMEOUT-1 go to FAULT.
- REL_VIDEO: video_rst=0; go to RUN next edge.
- RUN: usb_rst=0; stay.
- FAULT: all three resets high; init_timeout=1 (sticky until reset); stay.
- Lock loss: lock_s=0 in any state from STABLE to FAULT, inclusive.
  - Go to WAIT_LOCK.
  - All three resets high on that same edge.
  - lock_loss_cnt increments, saturating at 255.
  - Lock loss overrides every other transition.
  - A drop during STABLE counts as a lock-loss event.
- Reset outputs are registered, decoded from the next state, and glitch-free.
- Once deasserted, a reset output stays low until lock loss, FAULT or reset.
- Release order is strictly mem, then video, then usb. Deassertion of any reset implies all earlier ones are already deasserted.
- Counters are wide enough for their parameter: clog2 of the parameter value, minimum 1 bit.

## Timing
- Reset values: mem_rst=1, video_rst=1, usb_rst=1, seq_state=0, lock_loss_cnt=0, init_timeout=0.
- locked_in rising to lock_s=1: 2 edges.
- lock_s=1 to STABLE: 1 edge. STABLE to REL_MEM: LOCK_STABLE_CYCLES edges. mem_rst falls on the edge entering REL_MEM.
- mem_init_done sampled high in WAIT_INIT: video_rst falls on the next edge, and usb_rst falls one edge later.
- lock_s falling: all resets high on the next edge. Total from locked_in falling to resets high is at most 3 edges.
- mem_init_done is ignored outside WAIT_INIT.
- An asynchronous reset mid-sequence drops state to IDLE within the same cycle. The sequence restarts fully; there is no partial resume.

## Test plan
- LOCK_STABLE_CYCLES=8, INIT_TIMEOUT=32, locked_in high from reset release, mem_init_done raised 5 cycles after mem_rst falls -> mem_rst falls 11 edges after release (1 IDLE + 2 sync + 8 stable); video_rst falls 1 edge after init_done is seen; usb_rst falls 1 edge later; seq_state ends at 6.
- locked_in pulses low for 1 cycle at STABLE count 5 -> return to WAIT_LOCK, lock_loss_cnt=1, count restarts, mem_rst stays 1 throughout.
- mem_init_done never asserts -> FAULT 32 edges after entering WAIT_INIT, init_timeout=1, mem_rst back to 1, seq_state=7.
- In RUN, locked_in drops -> all resets high within 3 edges, seq_state=1, lock_loss_cnt increments. Relock -> full sequence repeats and init_timeout is unchanged.
- 300 lock-loss events -> lock_loss_cnt saturates at 255 and does not wrap.
- Assert reset asynchronously mid-WAIT_INIT -> outputs return to reset values without a clock edge; lock_loss_cnt=0.

Source files
------------

// File: rtl/rst_sequencer.sv
// Power-up / lock-loss reset sequencer in the mem_clk domain.
// Releases memory, then video (after SDRAM init), then USB; any lock loss restarts the sequence.
module rst_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int INIT_TIMEOUT       = 65536
) (
    input  logic       mem_clk,
    input  logic       reset,
    input  logic       locked_in,
    input  logic       mem_init_done,
    output logic       mem_rst,
    output logic       video_rst,
    output logic       usb_rst,
    output logic [2:0] seq_state,
    output logic [7:0] lock_loss_cnt,
    output logic       init_timeout
);

    localparam int STABLE_W  = ($clog2(LOCK_STABLE_CYCLES) > 0) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int TIMEOUT_W = ($clog2(INIT_TIMEOUT) > 0) ? $clog2(INIT_TIMEOUT) : 1;
    localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(INIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL_MEM   = 3'd3,
        ST_WAIT_INIT = 3'd4,
        ST_REL_VIDEO = 3'd5,
        ST_RUN       = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    state_t                 state_r;
    state_t                 seq_next_s;
    state_t                 next_state_s;
    logic                   lock_meta_r;
    logic                   lock_sync_r;
    logic                   lock_s;
    logic                   lock_loss_s;
    logic [STABLE_W-1:0]    stable_cnt_r;
    logic [TIMEOUT_W-1:0]   timeout_cnt_r;
    logic [7:0]             lock_loss_cnt_r;
    logic                   init_timeout_r;
    logic                   timeout_set_s;
    logic [2:0]             rst_next_s;
    logic                   mem_rst_r;
    logic                   video_rst_r;
    logic                   usb_rst_r;

    // Reset levels {usb, video, mem} held while in a given state; later resets never drop before earlier ones.
    function automatic logic [2:0] resets_for(input state_t st);
        case (st)
            ST_REL_MEM,
            ST_WAIT_INIT: resets_for = 3'b110;
            ST_REL_VIDEO: resets_for = 3'b100;
            ST_RUN:       resets_for = 3'b000;
            default:      resets_for = 3'b111;
        endcase
    endfunction

    assign lock_s      = lock_sync_r;
    assign lock_loss_s = (state_r != ST_IDLE) && (state_r != ST_WAIT_LOCK) && !lock_s;

    // Two-flop synchronizer for the raw PLL lock.
    always_ff @(posedge mem_clk or posedge reset) begin
        if (reset) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= locked_in;
            lock_sync_r <= lock_meta_r;
        end
    end

    // State register.
    always_ff @(posedge mem_clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; lock loss overrides every sequencing decision.
    always_comb begin
        seq_next_s   = state_r;
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:      seq_next_s = ST_WAIT_LOCK;
            ST_WAIT_LOCK: seq_next_s = lock_s ? ST_STABLE : ST_WAIT_LOCK;
            ST_STABLE:    seq_next_s = (stable_cnt_r == STABLE_LAST) ? ST_REL_MEM : ST_STABLE;
            ST_REL_MEM:   seq_next_s = ST_WAIT_INIT;
            ST_WAIT_INIT: begin
                if (mem_init_done) begin
                    seq_next_s = ST_REL_VIDEO;
                end else if (timeout_cnt_r == TIMEOUT_LAST) begin
                    seq_next_s = ST_FAULT;
                end else begin
                    seq_next_s = ST_WAIT_INIT;
                end
            end
            ST_REL_VIDEO: seq_next_s = ST_RUN;
            ST_RUN:       seq_next_s = ST_RUN;
            ST_FAULT:     seq_next_s = ST_FAULT;
            default:      seq_next_s = ST_IDLE;
        endcase
        if (lock_loss_s) begin
            next_state_s = ST_WAIT_LOCK;
        end else begin
            next_state_s = seq_next_s;
        end
    end

    // Output decode from the next state so the registered resets change on the transition edge.
    always_comb begin
        rst_next_s    = resets_for(next_state_s);
        timeout_set_s = (next_state_s == ST_FAULT);
    end

    // Registered reset outputs and sticky timeout flag.
    always_ff @(posedge mem_clk or posedge reset) begin
        if (reset) begin
            usb_rst_r      <= 1'b1;
            video_rst_r    <= 1'b1;
            mem_rst_r      <= 1'b1;
            init_timeout_r <= 1'b0;
        end else begin
            {usb_rst_r, video_rst_r, mem_rst_r} <= rst_next_s;
            if (timeout_set_s) begin
                init_timeout_r <= 1'b1;
            end
        end
    end

    // Lock-stable and init-timeout counters; each runs only in its own state.
    always_ff @(posedge mem_clk or posedge reset) begin
        if (reset) begin
            stable_cnt_r  <= '0;
            timeout_cnt_r <= '0;
        end else begin
            if ((state_r == ST_STABLE) && lock_s) begin
                stable_cnt_r <= stable_cnt_r + STABLE_W'(1);
            end else begin
                stable_cnt_r <= '0;
            end
            if (state_r == ST_WAIT_INIT) begin
                timeout_cnt_r <= timeout_cnt_r + TIMEOUT_W'(1);
            end else begin
                timeout_cnt_r <= '0;
            end
        end
    end

    // Saturating lock-loss event counter.
    always_ff @(posedge mem_clk or posedge reset) begin
        if (reset) begin
            lock_loss_cnt_r <= 8'd0;
        end else if (lock_loss_s && (lock_loss_cnt_r != 8'd255)) begin
            lock_loss_cnt_r <= lock_loss_cnt_r + 8'd1;
        end
    end

    assign mem_rst       = mem_rst_r;
    assign video_rst     = video_rst_r;
    assign usb_rst       = usb_rst_r;
    assign seq_state     = state_r;
    assign lock_loss_cnt = lock_loss_cnt_r;
    assign init_timeout  = init_timeout_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: vector table for the power-up sequence,
// hand-written sequences for lock loss, timeout, saturation and async reset.
module tb_rst_sequencer;

    logic       mem_clk;
    logic       reset;
    logic       locked_in;
    logic       mem_init_done;
    logic       mem_rst;
    logic       video_rst;
    logic       usb_rst;
    logic [2:0] seq_state;
    logic [7:0] lock_loss_cnt;
    logic       init_timeout;

    int checks = 0;
    int errors = 0;

    // {mem, video, usb} reset levels expected after the edge
    typedef struct {
        logic lk;
        logic init;
        int   st;
        int   rst;
    } vec_t;

    vec_t vq[$];

    rst_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .INIT_TIMEOUT(32)
    ) dut (
        .mem_clk(mem_clk),
        .reset(reset),
        .locked_in(locked_in),
        .mem_init_done(mem_init_done),
        .mem_rst(mem_rst),
        .video_rst(video_rst),
        .usb_rst(usb_rst),
        .seq_state(seq_state),
        .lock_loss_cnt(lock_loss_cnt),
        .init_timeout(init_timeout)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input int st, input int rst);
        check({name, "_state"}, int'(seq_state), st);
        check({name, "_rst"}, int'({mem_rst, video_rst, usb_rst}), rst);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge mem_clk);
        #1;
    endtask

    initial begin
        int exp_cnt;

        reset         = 1'b1;
        locked_in     = 1'b1;
        mem_init_done = 1'b0;
        step(2);
        check_outs("reset", 0, 7);
        check("reset_cnt", int'(lock_loss_cnt), 0);
        check("reset_timeout", int'(init_timeout), 0);

        // Power-up: edges 1..20 after reset release; init_done raised 5 cycles after mem_rst falls.
        vq.push_back('{1'b1, 1'b0, 1, 7});
        vq.push_back('{1'b1, 1'b0, 1, 7});
        for (int i = 3; i <= 10; i++) vq.push_back('{1'b1, 1'b0, 2, 7});
        vq.push_back('{1'b1, 1'b0, 3, 3});
        for (int i = 12; i <= 16; i++) vq.push_back('{1'b1, 1'b0, 4, 3});
        vq.push_back('{1'b1, 1'b1, 5, 1});
        for (int i = 18; i <= 20; i++) vq.push_back('{1'b1, 1'b1, 6, 0});

        reset = 1'b0;
        foreach (vq[i]) begin
            locked_in     = vq[i].lk;
            mem_init_done = vq[i].init;
            step(1);
            check_outs($sformatf("vec%0d", i + 1), vq[i].st, vq[i].rst);
        end

        // Lock loss in RUN: resets high on the third edge after locked_in falls.
        locked_in = 1'b0;
        step(2);
        check_outs("runloss_e2", 6, 0);
        step(1);
        check_outs("runloss_e3", 1, 7);
        check("runloss_cnt", int'(lock_loss_cnt), 1);

        // Relock with init_done already high: full sequence repeats.
        locked_in = 1'b1;
        step(10);
        check_outs("relock_stable", 2, 7);
        step(1);
        check_outs("relock_relmem", 3, 3);
        step(1);
        check_outs("relock_waitinit", 4, 3);
        step(1);
        check_outs("relock_relvideo", 5, 1);
        step(1);
        check_outs("relock_run", 6, 0);
        check("relock_timeout", int'(init_timeout), 0);
        check("relock_cnt", int'(lock_loss_cnt), 1);

        // Fresh start, then a one-cycle lock glitch at STABLE count 5.
        reset = 1'b1;
        step(2);
        reset         = 1'b0;
        mem_init_done = 1'b0;
        check("reset2_cnt", int'(lock_loss_cnt), 0);
        step(8);
        check_outs("glitch_pre", 2, 7);
        locked_in = 1'b0;
        step(1);
        locked_in = 1'b1;
        step(1);
        check_outs("glitch_e10", 2, 7);
        step(1);
        check_outs("glitch_waitlock", 1, 7);
        check("glitch_cnt", int'(lock_loss_cnt), 1);
        step(1);
        check_outs("glitch_restable", 2, 7);
        step(7);
        check_outs("glitch_count_restart", 2, 7);
        step(1);
        check_outs("glitch_relmem", 3, 3);

        // init_done never arrives: FAULT 32 edges after entering WAIT_INIT.
        step(1);
        check_outs("to_enter", 4, 3);
        step(31);
        check_outs("to_last", 4, 3);
        check("to_last_flag", int'(init_timeout), 0);
        step(1);
        check_outs("to_fault", 7, 7);
        check("to_fault_flag", int'(init_timeout), 1);
        step(3);
        check_outs("to_fault_hold", 7, 7);
        locked_in = 1'b0;
        step(3);
        check_outs("fault_loss", 1, 7);
        check("fault_loss_cnt", int'(lock_loss_cnt), 2);
        check("fault_loss_flag", int'(init_timeout), 1);

        // 300 more lock-loss events from STABLE: counter saturates at 255.
        exp_cnt = 2;
        for (int e = 0; e < 300; e++) begin
            locked_in = 1'b1;
            step(3);
            locked_in = 1'b0;
            step(3);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            check($sformatf("sat_cnt_ev%0d", e), int'(lock_loss_cnt), exp_cnt);
        end
        check_outs("sat_end", 1, 7);

        // Async reset in WAIT_INIT: outputs return to reset values with no clock edge.
        locked_in = 1'b1;
        step(11);
        check_outs("ar_relmem", 3, 3);
        step(3);
        check_outs("ar_waitinit", 4, 3);
        #2;
        reset = 1'b1;
        #1;
        check_outs("ar_async", 0, 7);
        check("ar_async_cnt", int'(lock_loss_cnt), 0);
        check("ar_async_flag", int'(init_timeout), 0);
        step(1);
        reset = 1'b0;
        step(1);
        check_outs("ar_restart", 1, 7);
        step(10);
        check_outs("ar_relmem2", 3, 3);
        step(1);

        // init_done on the final timeout cycle wins over the timeout.
        step(31);
        check_outs("prio_last", 4, 3);
        mem_init_done = 1'b1;
        step(1);
        check_outs("prio_relvideo", 5, 1);
        check("prio_flag", int'(init_timeout), 0);
        step(1);
        check_outs("prio_run", 6, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
